e1hdb3dec: RTL and testbench

- E1 receive line decoder, clocked by the recovered 2.048 MHz line clock.
- Sits between the LIU dual-rail outputs and the E1 Rx framer.
- Decodes HDB3 (B00V/000V substitutions) into the NRZ serial stream that drives the framer's `serin`.
- Generates the framer's `losdet` (G.775-style loss of signal).
- Flags line code violations and accumulates them in a latchable, saturating counter for the UPI.

---
 rtl/e1hdb3dec.sv | 128 ++++++++++++
 tb/tb_e1hdb3dec.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/e1hdb3dec.sv
// E1 receive line decoder: HDB3 dual-rail to NRZ for the Rx framer, loss-of-signal
// detection, and a latchable saturating code-violation counter for the UPI.
module e1hdb3dec #(
    parameter logic [7:0] LOSTHR = 8'd255,
    parameter logic [5:0] LOSWIN = 6'd32,
    parameter logic [5:0] LOSMIN = 6'd4,
    parameter int         CVW    = 16
) (
    input  logic           clk2,
    input  logic           rstn,
    input  logic           rpos,
    input  logic           rneg,
    input  logic           cvlat,
    output logic           serout,
    output logic           losdet,
    output logic           cverr,
    output logic [CVW-1:0] cvcnt
);

    logic           r_lastpol;
    logic           r_lastvpol;
    logic           r_havemark;
    logic [3:0]     r_dly;
    logic [7:0]     r_zrun;
    logic [5:0]     r_wcnt;
    logic [5:0]     r_wmarks;
    logic           r_losdet;
    logic           r_cverr;
    logic [CVW-1:0] r_cvint;
    logic [CVW-1:0] r_cvcnt;

    logic           w_mark;
    logic           w_both;
    logic           w_pol;
    logic           w_viol;
    logic           w_cv_vpol;
    logic           w_cv_zero;
    logic [7:0]     w_zrun_nxt;
    logic           w_wlast;
    logic [6:0]     w_wmarks_tot;
    logic           w_los_set;
    logic           w_los_clr;

    // A both-rail mark is treated as the legal alternate polarity, so it never
    // looks like a bipolar violation; it is flagged separately as a CV.
    assign w_mark       = rpos | rneg;
    assign w_both       = rpos & rneg;
    assign w_pol        = w_both ? ~r_lastpol : (rneg & ~rpos);
    assign w_viol       = w_mark & r_havemark & (w_pol == r_lastpol);
    assign w_cv_vpol    = w_viol & (w_pol == r_lastvpol);
    assign w_cv_zero    = ~w_mark & (r_zrun == 8'd3);

    assign w_zrun_nxt   = w_mark ? 8'd0 : ((r_zrun == 8'hFF) ? r_zrun : r_zrun + 8'd1);
    assign w_wlast      = (r_wcnt == LOSWIN - 6'd1);
    assign w_wmarks_tot = {1'b0, r_wmarks} + {6'd0, w_mark};
    assign w_los_set    = (w_zrun_nxt >= LOSTHR);
    assign w_los_clr    = w_wlast & (w_wmarks_tot >= {1'b0, LOSMIN}) & (w_zrun_nxt < LOSTHR);

    // Line polarity tracking and HDB3 decode pipeline.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_lastpol  <= 1'b1;
            r_lastvpol <= 1'b1;
            r_havemark <= 1'b0;
            r_dly      <= 4'd0;
        end else begin
            if (w_mark) begin
                r_lastpol  <= w_pol;
                r_havemark <= 1'b1;
            end
            if (w_viol) begin
                r_lastvpol <= w_pol;
            end
            // A violation zeroes the B position (dly[2]) as it moves into dly[3].
            r_dly <= {(w_viol ? 1'b0 : r_dly[2]), r_dly[1:0], (w_mark & ~w_viol)};
        end
    end

    // NOTE: serout is dly[3] itself; the four pipeline flops give the 4-cycle latency.
    assign serout = r_dly[3];

    // Loss of signal: zero-run threshold to set, per-window mark density to clear.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_zrun   <= 8'd0;
            r_wcnt   <= 6'd0;
            r_wmarks <= 6'd0;
            r_losdet <= 1'b1;
        end else begin
            r_zrun <= w_zrun_nxt;
            if (w_wlast) begin
                r_wcnt   <= 6'd0;
                r_wmarks <= 6'd0;
            end else begin
                r_wcnt   <= r_wcnt + 6'd1;
                r_wmarks <= w_wmarks_tot[5:0];
            end
            if (w_los_set) begin
                r_losdet <= 1'b1;
            end else if (w_los_clr && r_losdet) begin
                r_losdet <= 1'b0;
            end
        end
    end

    assign losdet = r_losdet;

    // Code-violation pulse and the latch/clear counter pair.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            r_cverr <= 1'b0;
            r_cvint <= '0;
            r_cvcnt <= '0;
        end else begin
            r_cverr <= w_both | w_cv_vpol | w_cv_zero;
            if (cvlat) begin
                r_cvcnt <= r_cvint;
                r_cvint <= CVW'(r_cverr);
            end else if (r_cverr && !(&r_cvint)) begin
                r_cvint <= r_cvint + CVW'(1);
            end
        end
    end

    assign cverr = r_cverr;
    assign cvcnt = r_cvcnt;

endmodule

// File: tb/tb_e1hdb3dec.sv
// Directed self-checking bench for e1hdb3dec: HDB3 decode, code violations,
// LOS entry/exit, CV counter handshake/saturation and asynchronous reset.
module tb_e1hdb3dec;

    logic        clk2 = 1'b0;
    logic        rstn;
    logic        rpos;
    logic        rneg;
    logic        cvlat;
    logic        serout;
    logic        losdet;
    logic        cverr;
    logic [15:0] cvcnt;

    int errors = 0;
    int checks = 0;
    int ecnt   = 0;

    always #5 clk2 = ~clk2;

    e1hdb3dec dut (
        .clk2   (clk2),
        .rstn   (rstn),
        .rpos   (rpos),
        .rneg   (rneg),
        .cvlat  (cvlat),
        .serout (serout),
        .losdet (losdet),
        .cverr  (cverr),
        .cvcnt  (cvcnt)
    );

    // Drive one line bit, let the edge sample it, then settle past the edge.
    task automatic cyc(input logic p, input logic n, input logic lat);
        rpos  = p;
        rneg  = n;
        cvlat = lat;
        @(posedge clk2);
        #1;
        ecnt++;
    endtask

    // Reset is released 1 time unit after an edge; the next edge is index 0.
    task automatic do_reset();
        rstn  = 1'b0;
        rpos  = 1'b0;
        rneg  = 1'b0;
        cvlat = 1'b0;
        repeat (2) @(posedge clk2);
        #1;
        rstn = 1'b1;
        ecnt = 0;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        rpos  = 1'b1;
        rneg  = 1'b0;
        cvlat = 1'b0;
        repeat (3) @(posedge clk2);
        #1;
        checks++; if (serout !== 1'b0) begin errors++; $display("FAIL reset serout: got %b want 0", serout); end
        checks++; if (losdet !== 1'b1) begin errors++; $display("FAIL reset losdet: got %b want 1", losdet); end
        checks++; if (cverr !== 1'b0) begin errors++; $display("FAIL reset cverr: got %b want 0", cverr); end
        checks++; if (cvcnt !== 16'd0) begin errors++; $display("FAIL reset cvcnt: got %0d want 0", cvcnt); end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int i = 0; i < 64; i++) begin
            cyc((i % 2) == 0, (i % 2) == 1, 1'b0);
            checks++; if (serout !== (i >= 3)) begin errors++; $display("FAIL alt serout edge %0d: got %b want %b", i, serout, (i >= 3)); end
            checks++; if (cverr !== 1'b0) begin errors++; $display("FAIL alt cverr edge %0d: got %b want 0", i, cverr); end
            checks++; if (losdet !== (i < 31)) begin errors++; $display("FAIL alt losdet edge %0d: got %b want %b", i, losdet, (i < 31)); end
        end
    endtask

    // N, B(P),0,0,V(P), N, 0,0,0,V(N), 0,0,0 with {rpos,rneg} encoding.
    task automatic test_b00v();
        logic [1:0] seq [13];
        logic       dec [13];
        logic       exp_s;
        seq = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
        dec = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(seq[i][1], seq[i][0], 1'b0);
            exp_s = (i >= 3) ? dec[i-3] : 1'b0;
            checks++; if (serout !== exp_s) begin errors++; $display("FAIL b00v serout edge %0d: got %b want %b", i, serout, exp_s); end
            checks++; if (cverr !== 1'b0) begin errors++; $display("FAIL b00v cverr edge %0d: got %b want 0", i, cverr); end
        end
    endtask

    // P, V(P), V(P) same-polarity pair, N, both-rail, N, six zeros, P, 0, 0.
    task automatic test_code_violations();
        logic [1:0] seq [15];
        logic       dec [15];
        logic       exp_s;
        logic       exp_c;
        seq = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        dec = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(seq[i][1], seq[i][0], 1'b0);
            exp_s = (i >= 3) ? dec[i-3] : 1'b0;
            exp_c = (i == 2) || (i == 4) || (i == 9);
            checks++; if (serout !== exp_s) begin errors++; $display("FAIL cv serout edge %0d: got %b want %b", i, serout, exp_s); end
            checks++; if (cverr !== exp_c) begin errors++; $display("FAIL cv cverr edge %0d: got %b want %b", i, cverr, exp_c); end
        end
    endtask

    task automatic test_los();
        logic p;
        p = 1'b1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            cyc(p, ~p, 1'b0);
            p = ~p;
        end
        checks++; if (losdet !== 1'b0) begin errors++; $display("FAIL los clear after marks: got %b want 0", losdet); end
        repeat (254) cyc(1'b0, 1'b0, 1'b0);
        checks++; if (losdet !== 1'b0) begin errors++; $display("FAIL los 254 zeros: got %b want 0", losdet); end
        cyc(p, ~p, 1'b0);
        p = ~p;
        checks++; if (losdet !== 1'b0) begin errors++; $display("FAIL los mark after 254: got %b want 0", losdet); end
        repeat (254) cyc(1'b0, 1'b0, 1'b0);
        checks++; if (losdet !== 1'b0) begin errors++; $display("FAIL los zero 254 of 255: got %b want 1->0 pending", losdet); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (losdet !== 1'b1) begin errors++; $display("FAIL los zero 255: got %b want 1", losdet); end
        while ((ecnt % 32) != 0) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i < 3) begin cyc(p, ~p, 1'b0); p = ~p; end
            else cyc(1'b0, 1'b0, 1'b0);
        end
        checks++; if (losdet !== 1'b1) begin errors++; $display("FAIL los 3-mark window: got %b want 1", losdet); end
        for (int i = 0; i < 31; i++) begin
            if (i < 4) begin cyc(p, ~p, 1'b0); p = ~p; end
            else cyc(1'b0, 1'b0, 1'b0);
        end
        checks++; if (losdet !== 1'b1) begin errors++; $display("FAIL los before 4-mark window end: got %b want 1", losdet); end
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (losdet !== 1'b0) begin errors++; $display("FAIL los 4-mark window end: got %b want 0", losdet); end
    endtask

    task automatic test_counter();
        do_reset();
        repeat (5) cyc(1'b1, 1'b1, 1'b0);
        checks++; if (cverr !== 1'b1) begin errors++; $display("FAIL cnt both-rail cverr: got %b want 1", cverr); end
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        checks++; if (cvcnt !== 16'd5) begin errors++; $display("FAIL cnt latch five: got %0d want 5", cvcnt); end
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        checks++; if (cvcnt !== 16'd0) begin errors++; $display("FAIL cnt latch after restart: got %0d want 0", cvcnt); end
        cyc(1'b0, 1'b1, 1'b1);
        checks++; if (cvcnt !== 16'd1) begin errors++; $display("FAIL cnt coincident latch: got %0d want 1", cvcnt); end
        repeat (65540) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        checks++; if (cvcnt !== 16'd1) begin errors++; $display("FAIL cnt hold between latches: got %0d want 1", cvcnt); end
        cyc(1'b0, 1'b0, 1'b1);
        checks++; if (cvcnt !== 16'hFFFF) begin errors++; $display("FAIL cnt saturation: got %h want ffff", cvcnt); end
    endtask

    task automatic test_async_reset();
        logic [1:0] seq [8];
        logic       dec [8];
        logic       exp_s;
        seq = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        dec = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        cyc(1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 40; i++) cyc((i % 2) == 0, (i % 2) == 1, (i == 2));
        checks++; if (cvcnt !== 16'd1) begin errors++; $display("FAIL arst pre cvcnt: got %0d want 1", cvcnt); end
        checks++; if (serout !== 1'b1) begin errors++; $display("FAIL arst pre serout: got %b want 1", serout); end
        checks++; if (losdet !== 1'b0) begin errors++; $display("FAIL arst pre losdet: got %b want 0", losdet); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (serout !== 1'b0) begin errors++; $display("FAIL arst serout: got %b want 0", serout); end
        checks++; if (losdet !== 1'b1) begin errors++; $display("FAIL arst losdet: got %b want 1", losdet); end
        checks++; if (cvcnt !== 16'd0) begin errors++; $display("FAIL arst cvcnt: got %0d want 0", cvcnt); end
        @(posedge clk2);
        #1;
        rstn = 1'b1;
        ecnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(seq[i][1], seq[i][0], 1'b0);
            exp_s = (i >= 3) ? dec[i-3] : 1'b0;
            checks++; if (serout !== exp_s) begin errors++; $display("FAIL arst resume serout edge %0d: got %b want %b", i, serout, exp_s); end
        end
        checks++; if (losdet !== 1'b1) begin errors++; $display("FAIL arst resume losdet: got %b want 1", losdet); end
    endtask

    initial begin
        rstn  = 1'b0;
        rpos  = 1'b0;
        rneg  = 1'b0;
        cvlat = 1'b0;
        test_reset();
        test_alternating();
        test_b00v();
        test_code_violations();
        test_los();
        test_counter();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
